dither_readback_spi_tx: RTL
===========================

Name: dither_readback_spi_tx

Overview:
- SPI-slave transmitter (mode 0, MSB first) that returns the dithered image to the MCU once the dithering controller raises read_on.
- Reads dithered pixels sequentially from the image SRAM read port and shifts each 8-bit pixel out on MISO under MCU-driven SCLK/CS_n.
- Sits between the image SRAM and the SPI pins, in parallel with the inbound SPI receive path.
- Entirely in the clk domain; SPI inputs are oversampled.

Parameters:
- IMAGEY, 256, image height in pixels
- IMAGEX, 256, image width in pixels
- IMAGE_SIZE, IMAGEY*IMAGEX, total bytes to transmit
- IMAGE_ADDR_WIDTH, $clog2(IMAGE_SIZE), SRAM address width
- RGB_SIZE, 8, bits per pixel word shifted out
- SRAM_LATENCY, 2, clk cycles from sram_rden to valid sram_q (1 or 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- read_on  in  1  level from dithering controller: image ready to read back
- spi_sclk  in  1  SPI clock from MCU (async; idle low)
- spi_cs_n  in  1  SPI chip select from MCU (async; active low)
- spi_miso  out  1  serial data to MCU
- sram_rdaddr  out  IMAGE_ADDR_WIDTH  SRAM read address
- sram_rden  out  1  SRAM read enable, one-cycle pulse per read
- sram_q  in  RGB_SIZE  SRAM read data
- busy  out  1  high from read_on accepted until done/abort
- done  out  1  one-cycle pulse after the last bit of byte IMAGE_SIZE-1
- tx_idx  out  IMAGE_ADDR_WIDTH  index of byte currently in the shift register

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; spi_miso=0, sram_rden=0, sram_rdaddr=0, busy=0, done=0, tx_idx=0; synchronizers cleared to sclk=0, cs_n=1.
- SCLK and CS_n each pass through 2-flop synchronizers; edges are detected on the synced values (3rd flop).
- Requirement: spi_sclk frequency <= clk/8. Faster SCLK is unsupported.
- States:
  - IDLE: on read_on rising edge (registered compare), go to PREFETCH with tx_idx=0 and busy=1.
  - PREFETCH: pulse sram_rden with addr 0; after SRAM_LATENCY cycles, load sram_q into the shift register and the holding register; go to ARMED.
  - ARMED: while cs_n is high, spi_miso=0.
    - On synced cs_n falling, drive shreg[MSB] on spi_miso; go to SHIFT.
    - Also in ARMED, issue the prefetch read of tx_idx+1 (if tx_idx < IMAGE_SIZE-1) into the next-byte register.
  - SHIFT: each synced sclk falling edge shifts left one bit and drives the new MSB; count synced sclk rising edges (3-bit).
    - On the 8th rising edge, the byte is complete.
    - If tx_idx == IMAGE_SIZE-1, go to DONE.
    - Otherwise tx_idx++, load the next-byte register into the shift and holding registers, drive its MSB on the next sclk falling edge, and issue the prefetch for tx_idx+1.
  - DONE: done=1 for one cycle, busy=0, spi_miso=0; wait for read_on low, then go to IDLE.
- MISO changes at most 4 clk after a physical sclk falling edge; this is within the half-period guaranteed by the clk/8 rule.
- cs_n rising mid-byte (bit count 1..7):
  - Abort the byte; restore the shift register from the holding register and clear the bit count; go to ARMED.
  - The same byte is retransmitted in full on the next cs_n fall.
- cs_n rising at a byte boundary: no rewind; go to ARMED and continue with the next byte.
- read_on falling in any state other than IDLE/DONE: abort to IDLE.
  - busy=0, done not pulsed, tx_idx=0.
  - Any in-flight SRAM read is discarded.
- sclk edges while cs_n is high: ignored.
- rst mid-transfer: immediate return to reset values; the next transfer restarts at byte 0.
- tx_idx never wraps. sram_rdaddr never exceeds IMAGE_SIZE-1, and no prefetch is issued past the last byte.

Test Plan:
- IMAGEX=IMAGEY=4, SRAM preloaded with addr i = 8'hA0+i. Raise read_on, drop cs_n, clock 128 sclk at clk/8. Required: MISO bytes A0..AF MSB-first; done pulses once after the 128th rising edge; busy then falls.
- Byte 0 = 8'h81. Required: MISO levels sampled on sclk rising edges read 1,0,0,0,0,0,0,1; MISO = 0 before cs_n falls.
- After 3 bits of byte 5 (8'hA5), raise cs_n, then lower it again. Required: a full 8'hA5 is retransmitted, followed by 8'hA6; tx_idx stays 5 across the gap.
- Toggle cs_n high/low exactly between bytes 2 and 3. Required: the stream continues with 8'hA3 with no repeat.
- Drop read_on after byte 7. Required: state returns to IDLE, busy=0, no done pulse. Re-raising read_on restarts at 8'hA0.
- Assert rst during byte 9 while sclk is toggling. Required: spi_miso=0, sram_rden=0, tx_idx=0 on the next cycle; sclk edges are ignored until read_on rises again.

Source files
------------

// File: rtl/dither_readback_spi_tx.sv
// SPI-slave (mode 0, MSB first) readback transmitter for the dithered image.
// Streams image SRAM bytes out on MISO under MCU-driven SCLK/CS_n, with the
// SPI pins oversampled in the clk domain and one byte prefetched ahead.
module dither_readback_spi_tx #(
    parameter int IMAGEY           = 256,
    parameter int IMAGEX           = 256,
    parameter int IMAGE_SIZE       = IMAGEY * IMAGEX,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int RGB_SIZE         = 8,
    parameter int SRAM_LATENCY     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        read_on,
    input  logic                        spi_sclk,
    input  logic                        spi_cs_n,
    output logic                        spi_miso,
    output logic [IMAGE_ADDR_WIDTH-1:0] sram_rdaddr,
    output logic                        sram_rden,
    input  logic [RGB_SIZE-1:0]         sram_q,
    output logic                        busy,
    output logic                        done,
    output logic [IMAGE_ADDR_WIDTH-1:0] tx_idx
);

    localparam int BCW = $clog2(RGB_SIZE);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_IDX = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [BCW-1:0]              LAST_BIT = BCW'(RGB_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_ARMED,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                        state_q;
    logic [2:0]                    sclk_sync_q;
    logic [2:0]                    cs_sync_q;
    logic                          read_on_q;
    logic [RGB_SIZE-1:0]           shreg_q;
    logic [RGB_SIZE-1:0]           hold_q;
    logic [RGB_SIZE-1:0]           nxt_q;
    logic                          nxt_vld_q;
    logic                          pend_q;      // freshly loaded byte, MSB not yet driven
    logic [BCW-1:0]                bitcnt_q;
    logic [SRAM_LATENCY-1:0]       rd_pipe_q;   // tracks the single in-flight SRAM read
    logic                          miso_q;
    logic [IMAGE_ADDR_WIDTH-1:0]   rdaddr_q;
    logic                          rden_q;
    logic                          busy_q;
    logic                          done_q;
    logic [IMAGE_ADDR_WIDTH-1:0]   tx_idx_q;

    logic [SRAM_LATENCY:0]         rd_pipe_d;
    logic                          rd_data_vld;
    logic                          need_fetch;
    logic                          sclk_rise;
    logic                          sclk_fall;
    logic                          cs_rise;
    logic                          cs_fall;
    logic                          abort;

    // Edges are taken between the second (synced) and third flop.
    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];

    assign rd_pipe_d   = {rd_pipe_q, rden_q};
    assign rd_data_vld = rd_pipe_q[SRAM_LATENCY-1];
    assign need_fetch  = !nxt_vld_q && !rden_q && (rd_pipe_q == '0) && (tx_idx_q != LAST_IDX);
    assign abort       = !read_on && (state_q inside {S_PREFETCH, S_ARMED, S_SHIFT});

    assign spi_miso    = miso_q;
    assign sram_rdaddr = rdaddr_q;
    assign sram_rden   = rden_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tx_idx      = tx_idx_q;

    // Synchronize the asynchronous SPI pins and register read_on for edge detect.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking assignments.
        if (rst) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            read_on_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
            read_on_q   <= read_on;
        end
    end

    // Readback FSM: prefetch, byte shifting, abort/rewind and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            hold_q    <= '0;
            nxt_q     <= '0;
            nxt_vld_q <= 1'b0;
            pend_q    <= 1'b0;
            bitcnt_q  <= '0;
            rd_pipe_q <= '0;
            miso_q    <= 1'b0;
            rdaddr_q  <= '0;
            rden_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_idx_q  <= '0;
        end else if (abort) begin
            state_q   <= S_IDLE;
            nxt_vld_q <= 1'b0;
            pend_q    <= 1'b0;
            bitcnt_q  <= '0;
            rd_pipe_q <= '0;
            miso_q    <= 1'b0;
            rden_q    <= 1'b0;
            busy_q    <= 1'b0;
            tx_idx_q  <= '0;
        end else begin
            rden_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_pipe_q <= rd_pipe_d[SRAM_LATENCY-1:0];

            // Keep the next-byte register filled while a byte is armed or shifting.
            if (state_q inside {S_ARMED, S_SHIFT}) begin
                if (rd_data_vld) begin
                    nxt_q     <= sram_q;
                    nxt_vld_q <= 1'b1;
                end else if (need_fetch) begin
                    rden_q   <= 1'b1;
                    rdaddr_q <= tx_idx_q + IMAGE_ADDR_WIDTH'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    miso_q <= 1'b0;
                    if (read_on && !read_on_q) begin
                        state_q   <= S_PREFETCH;
                        tx_idx_q  <= '0;
                        busy_q    <= 1'b1;
                        rden_q    <= 1'b1;
                        rdaddr_q  <= '0;
                        nxt_vld_q <= 1'b0;
                        bitcnt_q  <= '0;
                    end
                end
                S_PREFETCH: begin
                    if (rd_data_vld) begin
                        shreg_q <= sram_q;
                        hold_q  <= sram_q;
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        miso_q  <= shreg_q[RGB_SIZE-1];
                        pend_q  <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cs_rise) begin
                        state_q <= S_ARMED;
                        miso_q  <= 1'b0;
                        if (bitcnt_q != '0) begin
                            shreg_q  <= hold_q;
                            bitcnt_q <= '0;
                        end
                    end else if (sclk_rise) begin
                        if (bitcnt_q == LAST_BIT) begin
                            bitcnt_q <= '0;
                            if (tx_idx_q == LAST_IDX) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                miso_q  <= 1'b0;
                            end else begin
                                tx_idx_q  <= tx_idx_q + IMAGE_ADDR_WIDTH'(1);
                                shreg_q   <= nxt_q;
                                hold_q    <= nxt_q;
                                nxt_vld_q <= 1'b0;
                                pend_q    <= 1'b1;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + BCW'(1);
                        end
                    end else if (sclk_fall) begin
                        if (pend_q) begin
                            miso_q <= shreg_q[RGB_SIZE-1];
                            pend_q <= 1'b0;
                        end else begin
                            shreg_q <= shreg_q << 1;
                            miso_q  <= shreg_q[RGB_SIZE-2];
                        end
                    end
                end
                S_DONE: begin
                    miso_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (!read_on) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
